// File: rtl/lognet_input_packer.sv
// Quantizes signed feature words to CODE_W-bit codes and packs NUM_FEATURES codes per output vector.
// Optional macro LOGNET_PACKER_CNT_EN adds vec_count/err_count statistics outputs.
module lognet_input_packer #(
    parameter int unsigned NUM_FEATURES = 16,
    parameter int unsigned FEAT_W       = 16,
    parameter int unsigned CODE_W       = 2,
    parameter int unsigned IN_SHIFT     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [FEAT_W-1:0]              s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_FEATURES*CODE_W-1:0] m_data,
    output logic                           frame_err
`ifdef LOGNET_PACKER_CNT_EN
    ,
    output logic [15:0]                    vec_count,
    output logic [15:0]                    err_count
`endif
);

    localparam int unsigned IDX_W    = $clog2(NUM_FEATURES);
    localparam int unsigned VEC_W    = NUM_FEATURES * CODE_W;
    localparam int unsigned CODE_MAX = (1 << CODE_W) - 1;

    logic [IDX_W-1:0]         idx;
    logic [VEC_W-1:0]         asm_q;
    logic [VEC_W-1:0]         merged;
    logic signed [FEAT_W-1:0] q;
    logic [CODE_W-1:0]        code;
    logic                     last_slot;
    logic                     out_free;
    logic                     word_xfer;
    logic                     complete;
    logic                     drop;

    // Shift-and-saturate quantizer
    always_comb begin
        q = $signed(s_data) >>> IN_SHIFT;
        if (q[FEAT_W-1]) begin
            code = '0;
        end else if ($unsigned(q) >= FEAT_W'(CODE_MAX)) begin
            code = CODE_W'(CODE_MAX);
        end else begin
            code = q[CODE_W-1:0];
        end
    end

    // Only the completing word can stall; it needs the output register free
    assign last_slot = (idx == IDX_W'(NUM_FEATURES - 1));
    assign out_free  = !m_valid || m_ready;
    assign s_ready   = !last_slot || out_free;
    assign word_xfer = s_valid && s_ready;
    assign complete  = word_xfer && last_slot && s_last;
    assign drop      = word_xfer && (last_slot != s_last);

    always_comb begin
        merged = asm_q;
        merged[int'(idx)*CODE_W +: CODE_W] = code;
    end

    // Assembly slot index and partial vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (word_xfer) begin
            if (complete || drop) begin
                idx   <= '0;
                asm_q <= '0;
            end else begin
                idx   <= idx + IDX_W'(1);
                asm_q <= merged;
            end
        end
    end

    // Output register: load on completion, otherwise hold until drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= drop;
            if (complete) begin
                m_valid <= 1'b1;
                m_data  <= merged;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef LOGNET_PACKER_CNT_EN
    // Wrapping statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count <= '0;
            err_count <= '0;
        end else begin
            vec_count <= vec_count + 16'(m_valid && m_ready);
            err_count <= err_count + 16'(frame_err);
        end
    end
`endif

endmodule
